sincos_arbiter: RTL and testbench

SINCOS_ARBITER -- requirements
Module: sincos_arbiter

---
 rtl/sincos_arbiter.sv | 142 ++++++++++++++
 tb/tb_sincos_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_arbiter.sv
// Round-robin arbiter sharing one pipelined sin/cos core among N_REQ requesters.
// A tag line tracks each issued angle so its result is routed back to the originating requester.
module sincos_arbiter #(
    parameter int N_REQ   = 2,
    parameter int LATENCY = 17
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [N_REQ*18-1:0]   req_theta,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    output logic [17:0]           core_theta_tdata,
    output logic                  core_theta_tvalid,
    input  logic [33:0]           core_sin_cos_tdata,
    input  logic                  core_sin_cos_tvalid,
    output logic [N_REQ*34-1:0]   res_tdata,
    output logic [N_REQ-1:0]      res_tvalid,
    output logic                  idle,
    output logic                  err
);

    localparam int DATA_W = 18;
    localparam int RES_W  = 34;
    localparam int IDX_W  = $clog2(N_REQ);
    localparam int CNT_W  = $clog2(LATENCY + 2);

    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_found;
    logic                     xfer;
    logic signed [DATA_W-1:0] theta_sel;
    logic [IDX_W-1:0]         idx_p0;

    logic                     tag_vld [LATENCY];
    logic [IDX_W-1:0]         tag_idx [LATENCY];
    logic                     exit_vld;
    logic [IDX_W-1:0]         exit_idx;

    logic [CNT_W-1:0]         inflight;

    // Scan from the requester after the last winner, wrapping around.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_found && req_valid[i] && (i == (int'(rr_ptr) + k) % N_REQ)) begin
                    grant_found = 1'b1;
                    grant_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        theta_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = en && grant_found && (grant_idx == IDX_W'(i));
            if (grant_idx == IDX_W'(i)) begin
                theta_sel = req_theta[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer = en && grant_found;

    // Stage p0: registered angle and owner index to the core
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr            <= IDX_W'(N_REQ - 1);
            core_theta_tvalid <= 1'b0;
            core_theta_tdata  <= '0;
            idx_p0            <= '0;
        end else begin
            core_theta_tvalid <= xfer;
            core_theta_tdata  <= xfer ? theta_sel : '0;
            idx_p0            <= grant_idx;
            if (xfer) begin
                rr_ptr <= grant_idx;
            end
        end
    end

    // Tag line: mirrors the core pipeline so the owner pops out with its result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_vld[k] <= 1'b0;
                tag_idx[k] <= '0;
            end
        end else begin
            tag_vld[0] <= core_theta_tvalid;
            tag_idx[0] <= idx_p0;
            for (int k = 1; k < LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

    assign exit_vld = tag_vld[LATENCY-1];
    assign exit_idx = tag_idx[LATENCY-1];

    // Result stage: route core output to its owner, flag any tag/valid disagreement
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_tvalid <= '0;
            res_tdata  <= '0;
            err        <= 1'b0;
        end else begin
            res_tvalid <= '0;
            if (exit_vld && core_sin_cos_tvalid) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (exit_idx == IDX_W'(i)) begin
                        res_tvalid[i]                <= 1'b1;
                        res_tdata[i*RES_W +: RES_W]  <= core_sin_cos_tdata;
                    end
                end
            end
            if (exit_vld != core_sin_cos_tvalid) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= '0;
        end else begin
            case ({xfer, exit_vld})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign idle = (inflight == '0);

endmodule

// File: tb/tb_sincos_arbiter.sv
// Randomized bench for sincos_arbiter with a delay-line core model and a transaction-level reference.
module tb_sincos_arbiter;

    localparam int N  = 2;
    localparam int L  = 17;
    localparam int TW = N * 18;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            en = 1'b0;
    logic [TW-1:0]   req_theta = '0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [17:0]     core_theta_tdata;
    logic            core_theta_tvalid;
    logic [33:0]     core_sin_cos_tdata;
    logic            core_sin_cos_tvalid;
    logic [N*34-1:0] res_tdata;
    logic [N-1:0]    res_tvalid;
    logic            idle;
    logic            err;

    sincos_arbiter #(.N_REQ(N), .LATENCY(L)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .en                  (en),
        .req_theta           (req_theta),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .core_theta_tdata    (core_theta_tdata),
        .core_theta_tvalid   (core_theta_tvalid),
        .core_sin_cos_tdata  (core_sin_cos_tdata),
        .core_sin_cos_tvalid (core_sin_cos_tvalid),
        .res_tdata           (res_tdata),
        .res_tvalid          (res_tvalid),
        .idle                (idle),
        .err                 (err)
    );

    always #5 clk = ~clk;

    // External core: fixed-latency pipe, independent of the arbiter's reset
    logic        core_clr = 1'b1;
    logic        inject = 1'b0;
    logic        cv [L];
    logic [17:0] cd [L];

    function automatic logic [33:0] fcore(input logic [17:0] t);
        return {t ^ 18'h2A5A5, t[15:0]};
    endfunction

    always @(posedge clk) begin
        if (core_clr) begin
            for (int k = 0; k < L; k++) begin
                cv[k] <= 1'b0;
                cd[k] <= '0;
            end
        end else begin
            cv[0] <= core_theta_tvalid;
            cd[0] <= core_theta_tdata;
            for (int k = 1; k < L; k++) begin
                cv[k] <= cv[k-1];
                cd[k] <= cd[k-1];
            end
        end
    end

    assign core_sin_cos_tvalid = cv[L-1] | inject;
    assign core_sin_cos_tdata  = inject ? 34'h155AA33CC : fcore(cd[L-1]);

    // Reference model: outstanding transactions with the edge they were accepted on
    typedef struct {
        int          idx;
        logic [17:0] th;
        int          h;
    } ent_t;

    ent_t            q[$];
    int              mptr = N - 1;
    logic            model_err = 1'b0;
    logic [N*34-1:0] res_m = '0;
    logic            hs_last = 1'b0;
    logic [17:0]     th_last = '0;
    int              cyc = 0;
    int              n_chk = 0;
    int              n_fail = 0;

    task automatic chk(input string tag, input logic [67:0] act, input logic [67:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] rv;
        rv = '0;
        chk("core_tvalid", 68'(core_theta_tvalid), 68'(hs_last));
        chk("core_tdata", 68'(core_theta_tdata), 68'(hs_last ? th_last : 18'h0));
        for (int j = q.size() - 1; j >= 0; j--) begin
            if (q[j].h + L + 1 == cyc) begin
                rv[q[j].idx] = 1'b1;
                res_m[q[j].idx*34 +: 34] = fcore(q[j].th);
                q.delete(j);
            end
        end
        chk("res_tvalid", 68'(res_tvalid), 68'(rv));
        chk("res_tdata", 68'(res_tdata), 68'(res_m));
        chk("idle", 68'(idle), 68'(q.size() == 0));
        chk("err", 68'(err), 68'(model_err));
    endtask

    // One clock: drive at the falling edge, check grant, then check registered outputs
    task automatic run_cycle(input logic [N-1:0] v, input logic e, input logic [TW-1:0] th,
                             input logic inj);
        logic [N-1:0] er;
        int           g;
        logic         exitx;
        req_valid = v;
        en        = e;
        req_theta = th;
        inject    = inj;
        #1;
        er = '0;
        g  = -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (mptr + k) % N;
            if (g < 0 && v[c]) g = c;
        end
        if (e && g >= 0) er[g] = 1'b1;
        chk("req_ready", 68'(req_ready), 68'(er));
        exitx = 1'b0;
        foreach (q[j]) if (q[j].h + L == cyc) exitx = 1'b1;
        if (exitx != core_sin_cos_tvalid) model_err = 1'b1;
        @(posedge clk);
        cyc++;
        hs_last = e && (g >= 0);
        if (hs_last) begin
            th_last = th[g*18 +: 18];
            q.push_back('{g, th_last, cyc});
            mptr = g;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        req_valid = '0;
        en        = 1'b0;
        inject    = 1'b0;
        rstn      = 1'b0;
        #1;
        chk("rst_core_tvalid", 68'(core_theta_tvalid), 68'(0));
        chk("rst_core_tdata", 68'(core_theta_tdata), 68'(0));
        chk("rst_res_tvalid", 68'(res_tvalid), 68'(0));
        chk("rst_res_tdata", 68'(res_tdata), 68'(0));
        chk("rst_idle", 68'(idle), 68'(1));
        chk("rst_err", 68'(err), 68'(0));
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rstn = 1'b1;
        q.delete();
        mptr      = N - 1;
        model_err = 1'b0;
        res_m     = '0;
        hs_last   = 1'b0;
        check_outputs();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) run_cycle('0, 1'b1, '0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        core_clr = 1'b0;
        do_reset();

        // Disabled issue with both requesting: nothing granted, stays idle
        for (int i = 0; i < 4; i++) run_cycle(2'b11, 1'b0, {18'h01234, 18'h05678}, 1'b0);

        // Single requester back-to-back
        for (int i = 0; i < 3; i++) run_cycle(2'b01, 1'b1, {18'h3FFFF, 18'h0C90F}, 1'b0);
        drain(L + 4);

        // Both requesting: grants alternate, results return to the right channel
        for (int i = 0; i < 6; i++) run_cycle(2'b11, 1'b1, {18'h2_0001 + 18'(i), 18'h1_0100 + 18'(i)}, 1'b0);
        drain(L + 4);

        // Long saturated stream: issue and retire coincide every cycle
        for (int i = 0; i < L + 6; i++) run_cycle(2'b10, 1'b1, TW'({$urandom(), $urandom()}), 1'b0);
        drain(L + 4);

        // Stream then disable mid-flight; tags drain normally
        for (int i = 0; i < 5; i++) run_cycle(2'b11, 1'b1, TW'({$urandom(), $urandom()}), 1'b0);
        for (int i = 0; i < L + 4; i++) run_cycle(2'b11, 1'b0, TW'({$urandom(), $urandom()}), 1'b0);

        // Random traffic with random enable gaps
        for (int i = 0; i < 400; i++) begin
            run_cycle(N'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
                      TW'({$urandom(), $urandom()}), 1'b0);
        end
        drain(L + 4);

        // Reset in the middle of five transfers: stale core results must be dropped and flagged
        for (int i = 0; i < 5; i++) run_cycle(2'b01, 1'b1, TW'({$urandom(), $urandom()}), 1'b0);
        do_reset();
        drain(L + 4);
        chk("err_after_stale", 68'(err), 68'(1));
        do_reset();

        // Spurious core valid on an empty tag line
        drain(2);
        run_cycle('0, 1'b1, '0, 1'b1);
        drain(6);
        chk("err_sticky", 68'(err), 68'(1));
        do_reset();
        drain(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
